// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem read, IF/ID register.
// Define FETCH_PERF_CNT_EN to add the cnt_fetch/cnt_drop counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0400_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  input  logic        stall_d,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] instr_d,
  output logic [5:0]  op_d,
  output logic [31:0] pcplus4_d,
  output logic        valid_d
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] cnt_fetch,
  output logic [31:0] cnt_drop
`endif
);

  typedef enum logic [1:0] {
    ISSUE,
    WAIT,
    HOLD
  } state_t;

  localparam logic [31:0] AMASK = 32'hFFFF_FFFC;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] pc4, tgt;
  logic [31:0] hbuf, hbuf_n;
  logic [31:0] ld_word, ld_pc4;
  logic        discard, discard_n;
  logic        redirect, ld;

  assign redirect  = branch_taken | jump;
  assign tgt       = (jump ? jump_target : branch_target) & AMASK;
  assign pc4       = pc + 32'd4;
  assign imem_req  = (state == ISSUE) && !reset;
  assign imem_addr = pc;
  assign op_d      = instr_d[31:26];

  // Next state, next PC, hold buffer and IF/ID load selection
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    discard_n = discard;
    hbuf_n    = hbuf;
    ld        = 1'b0;
    ld_word   = imem_rdata;
    ld_pc4    = pc4;
    unique case (state)
      ISSUE: begin
        state_n = WAIT;
        if (redirect) discard_n = 1'b1;
      end
      WAIT: begin
        if (imem_valid) begin
          if (discard || redirect) begin
            discard_n = 1'b0;
            state_n   = ISSUE;
          end else if (!stall_d) begin
            ld      = 1'b1;
            pc_n    = pc4;
            state_n = ISSUE;
          end else begin
            hbuf_n  = imem_rdata;
            pc_n    = pc4;
            state_n = HOLD;
          end
        end else if (redirect) begin
          discard_n = 1'b1;
        end
      end
      HOLD: begin
        if (redirect) begin
          state_n = ISSUE;
        end else if (!stall_d) begin
          ld      = 1'b1;
          ld_word = hbuf;
          ld_pc4  = pc;
          state_n = ISSUE;
        end
      end
      default: state_n = ISSUE;
    endcase
    if (redirect) pc_n = tgt;
  end

  // Fetch control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ISSUE;
      pc      <= RESET_PC & AMASK;
      discard <= 1'b0;
      hbuf    <= '0;
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      discard <= discard_n;
      hbuf    <= hbuf_n;
    end
  end

  // IF/ID register: flush on redirect, load, drain or hold
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_d   <= NOP_INSTR;
      pcplus4_d <= '0;
      valid_d   <= 1'b0;
    end else if (redirect) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end else if (ld) begin
      instr_d   <= ld_word;
      pcplus4_d <= ld_pc4;
      valid_d   <= 1'b1;
    end else if (!stall_d) begin
      instr_d <= NOP_INSTR;
      valid_d <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic dropped;

  assign dropped =
    ((state == WAIT) && imem_valid && (discard || redirect)) ||
    ((state == HOLD) && redirect);

  // Delivered and dropped word counters
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_fetch <= '0;
      cnt_drop  <= '0;
    end else begin
      if (ld) cnt_fetch <= cnt_fetch + 32'd1;
      if (dropped) cnt_drop <= cnt_drop + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed table plus randomized run
// against a queue-based fetch reference model.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0400_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic        stall_d;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        jump;
  logic [31:0] jump_target;
  logic [31:0] instr_d;
  logic [5:0]  op_d;
  logic [31:0] pcplus4_d;
  logic        valid_d;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] cnt_fetch;
  logic [31:0] cnt_drop;
`endif

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .stall_d      (stall_d),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .instr_d      (instr_d),
    .op_d         (op_d),
    .pcplus4_d    (pcplus4_d),
    .valid_d      (valid_d)
`ifdef FETCH_PERF_CNT_EN
    ,
    .cnt_fetch    (cnt_fetch),
    .cnt_drop     (cnt_drop)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        stall;
    logic        bt;
    logic [31:0] bta;
    logic        j;
    logic [31:0] jt;
    logic        mv;
    logic [31:0] md;
    logic        ereq;
    logic [31:0] eaddr;
    logic [31:0] einstr;
    logic [31:0] epc4;
    logic        evalid;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, input logic stall, input logic bt,
    input logic [31:0] bta, input logic j, input logic [31:0] jt,
    input logic mv, input logic [31:0] md, input logic ereq,
    input logic [31:0] eaddr, input logic [31:0] einstr,
    input logic [31:0] epc4, input logic evalid);
    vec_t v;
    v.rst = rst; v.stall = stall; v.bt = bt; v.bta = bta;
    v.j = j; v.jt = jt; v.mv = mv; v.md = md;
    v.ereq = ereq; v.eaddr = eaddr; v.einstr = einstr;
    v.epc4 = epc4; v.evalid = evalid;
    return v;
  endfunction

  vec_t tbl[22];

  // reference model state
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid, m_out, m_stale;
  logic [31:0] m_held[$];
  logic [31:0] m_fetch, m_drop;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task model_step();
    logic        redir, dl;
    logic [31:0] tg, dword, dpc4;
    if (reset) begin
      m_pc = 32'h0; m_out = 0; m_stale = 0; m_held.delete();
      m_instr = NOP; m_pc4 = 0; m_valid = 0;
      m_fetch = 0; m_drop = 0;
    end else begin
      redir = branch_taken | jump;
      tg = jump ? jump_target : branch_target;
      tg[1:0] = 2'b00;
      dl = 0; dword = 0; dpc4 = 0;
      if (!m_out && m_held.size() == 0) begin
        m_out = 1;
        m_stale = redir;
      end else if (m_out) begin
        if (imem_valid) begin
          m_out = 0;
          if (m_stale || redir) begin
            m_stale = 0;
            m_drop++;
          end else if (!stall_d) begin
            dl = 1; dword = imem_rdata; dpc4 = m_pc + 4;
            m_pc = m_pc + 4;
          end else begin
            m_held.push_back(imem_rdata);
            m_pc = m_pc + 4;
          end
        end else if (redir) begin
          m_stale = 1;
        end
      end else begin
        if (redir) begin
          m_held.delete();
          m_drop++;
        end else if (!stall_d) begin
          dl = 1; dword = m_held.pop_front(); dpc4 = m_pc;
        end
      end
      if (redir) begin
        m_pc = tg; m_instr = NOP; m_valid = 0;
      end else if (dl) begin
        m_instr = dword; m_pc4 = dpc4; m_valid = 1; m_fetch++;
      end else if (!stall_d) begin
        m_instr = NOP; m_valid = 0;
      end
    end
  endtask

  task compare_model();
    logic ereq;
    ereq = !m_out && (m_held.size() == 0);
    chk("rnd_req", {31'b0, imem_req}, {31'b0, ereq});
    if (ereq) chk("rnd_addr", imem_addr, m_pc);
    chk("rnd_instr", instr_d, m_instr);
    chk("rnd_op", {26'b0, op_d}, {26'b0, m_instr[31:26]});
    chk("rnd_pc4", pcplus4_d, m_pc4);
    chk("rnd_valid", {31'b0, valid_d}, {31'b0, m_valid});
`ifdef FETCH_PERF_CNT_EN
    chk("rnd_cnt_fetch", cnt_fetch, m_fetch);
    chk("rnd_cnt_drop", cnt_drop, m_drop);
`endif
  endtask

  logic        pend;
  int          mcnt;
  logic [31:0] paddr;

  initial begin
    tbl[0]  = mk(1,0,0,0,0,0,0,0, 0,0, NOP,0,0);
    tbl[1]  = mk(0,0,0,0,0,0,0,0, 1,0, NOP,0,0);
    tbl[2]  = mk(0,0,0,0,0,0,1,32'h8C08_0004, 0,0, 32'h8C08_0004,4,1);
    tbl[3]  = mk(0,1,0,0,0,0,0,0, 1,4, 32'h8C08_0004,4,1);
    tbl[4]  = mk(0,1,0,0,0,0,1,32'h2008_0005, 0,0, 32'h8C08_0004,4,1);
    tbl[5]  = mk(0,1,0,0,0,0,0,0, 0,0, 32'h8C08_0004,4,1);
    tbl[6]  = mk(0,0,0,0,0,0,0,0, 0,0, 32'h2008_0005,8,1);
    tbl[7]  = mk(0,0,0,0,0,0,0,0, 1,8, NOP,8,0);
    tbl[8]  = mk(0,0,1,32'h40,0,0,0,0, 0,0, NOP,8,0);
    tbl[9]  = mk(0,0,0,0,0,0,1,32'hDEAD_BEEF, 0,0, NOP,8,0);
    tbl[10] = mk(0,0,1,32'h80,1,32'h103,0,0, 1,32'h40, NOP,8,0);
    tbl[11] = mk(0,0,0,0,0,0,1,32'hBAD0_BAD0, 0,0, NOP,8,0);
    tbl[12] = mk(0,0,0,0,1,32'hFFFF_FFFC,0,0, 1,32'h100, NOP,8,0);
    tbl[13] = mk(0,0,0,0,0,0,1,32'h1234_5678, 0,0, NOP,8,0);
    tbl[14] = mk(0,0,0,0,0,0,0,0, 1,32'hFFFF_FFFC, NOP,8,0);
    tbl[15] = mk(0,0,0,0,0,0,1,32'h8C09_0008, 0,0, 32'h8C09_0008,0,1);
    tbl[16] = mk(0,0,0,0,0,0,0,0, 1,0, NOP,0,0);
    tbl[17] = mk(0,1,0,0,0,0,1,32'h1111_1111, 0,0, NOP,0,0);
    tbl[18] = mk(1,1,0,0,0,0,0,0, 0,0, NOP,0,0);
    tbl[19] = mk(0,0,0,0,0,0,0,0, 1,0, NOP,0,0);
    tbl[20] = mk(0,0,0,0,0,0,1,32'h2222_2222, 0,0, 32'h2222_2222,4,1);
    tbl[21] = mk(0,0,0,0,0,0,0,0, 1,4, NOP,4,0);

    reset = 1; stall_d = 0; branch_taken = 0; branch_target = 0;
    jump = 0; jump_target = 0; imem_valid = 0; imem_rdata = 0;
    pend = 0; mcnt = 0; paddr = 0;

    @(negedge clk);
    for (int i = 0; i < 22; i++) begin
      reset = tbl[i].rst;
      stall_d = tbl[i].stall;
      branch_taken = tbl[i].bt;
      branch_target = tbl[i].bta;
      jump = tbl[i].j;
      jump_target = tbl[i].jt;
      imem_valid = tbl[i].mv;
      imem_rdata = tbl[i].md;
      #1;
      chk($sformatf("v%0d_req", i), {31'b0, imem_req},
          {31'b0, tbl[i].ereq});
      if (tbl[i].ereq)
        chk($sformatf("v%0d_addr", i), imem_addr, tbl[i].eaddr);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("v%0d_instr", i), instr_d, tbl[i].einstr);
      chk($sformatf("v%0d_op", i), {26'b0, op_d},
          {26'b0, tbl[i].einstr[31:26]});
      chk($sformatf("v%0d_pc4", i), pcplus4_d, tbl[i].epc4);
      chk($sformatf("v%0d_valid", i), {31'b0, valid_d},
          {31'b0, tbl[i].evalid});
`ifdef FETCH_PERF_CNT_EN
      if (i == 19) begin
        chk("v19_cnt_fetch", cnt_fetch, 32'd0);
        chk("v19_cnt_drop", cnt_drop, 32'd0);
      end
`endif
    end

    reset = 1; stall_d = 0; branch_taken = 0; jump = 0;
    imem_valid = 0; pend = 0;
    repeat (2) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
    end
    reset = 0;
    #1;
    for (int c = 0; c < 3000; c++) begin
      compare_model();
      imem_valid = 0;
      if (pend) begin
        mcnt--;
        if (mcnt == 0) begin
          imem_valid = 1;
          imem_rdata = memf(paddr);
          pend = 0;
        end
      end
      if (imem_req) begin
        pend = 1;
        mcnt = $urandom_range(1, 3);
        paddr = imem_addr;
      end
      stall_d = ($urandom_range(0, 9) < 3);
      branch_taken = ($urandom_range(0, 99) < 8);
      jump = ($urandom_range(0, 99) < 5);
      branch_target = $urandom;
      jump_target = $urandom;
      @(posedge clk);
      model_step();
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
